// File: rtl/urv_uart_pkg.sv
// Shared definitions for the urv AHB UART: register offsets, STATUS bits, FSM states.
package urv_uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam int ST_TX_FULL   = 0;
  localparam int ST_TX_IDLE   = 1;
  localparam int ST_RX_VALID  = 2;
  localparam int ST_OVERRUN   = 3;
  localparam int ST_FRAME_ERR = 4;

  localparam logic [15:0] DIV_MIN = 16'd2;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // Address-phase capture, consumed in the following data phase.
  typedef struct packed {
    logic       vld;
    logic       write;
    logic [1:0] addr;
  } dphase_t;

endpackage

// File: rtl/urv_sync_fifo.sv
// Single-clock FIFO; read data is the head entry (no read latency).
// A push while full is ignored, even with a simultaneous pop; a pop while empty is ignored.
module urv_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam int DEPTH = 2**AW;
  localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == DEPTH_W);
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign pop_dat = mem[rptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop_ok)  rptr <= rptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/urv_ahb_uart.sv
// AHB-Lite UART slave: 8-deep TX FIFO, 8N1 serializer/deserializer, programmable bit period.
// Zero wait states, accesses act in the data phase; DATA writes into a full FIFO are dropped.
module urv_ahb_uart
  import urv_uart_pkg::*;
#(
  parameter int          TXFIFO_AW = 3,
  parameter logic [15:0] DIV_RESET = 16'd868
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        HRESP,
  output logic        TXD,
  input  logic        RXD,
  output logic        IRQ
);

  dphase_t             dp;
  logic [15:0]         div;
  logic                wr_data, wr_status, wr_div, rd_clr;
  logic                tx_full, tx_empty, tx_pop, tx_idle;
  logic [7:0]          tx_head;
  logic [TXFIFO_AW:0]  tx_count;
  tx_state_t           tx_state;
  logic [15:0]         tx_cnt;
  logic [2:0]          tx_idx;
  logic [7:0]          tx_shreg;
  rx_state_t           rx_state;
  logic [15:0]         rx_cnt;
  logic [2:0]          rx_idx;
  logic [7:0]          rx_shreg, rx_buf;
  logic [1:0]          rx_sync;
  logic                rx_s, rx_prev, rx_stop_evt, rx_stop_ok;
  logic                rx_valid, overrun, frame_err;
  logic [4:0]          status;
  logic                unused_ok;

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign IRQ       = rx_valid | overrun;
  assign unused_ok = ^{HSIZE, HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA[31:16]};

  always_ff @(posedge CLK) begin
    if (RST) dp <= '0;
    else     dp <= '{vld: HSEL & HREADY & HTRANS[1], write: HWRITE, addr: HADDR[3:2]};
  end

  assign wr_data   = dp.vld & dp.write & (dp.addr == REG_DATA);
  assign wr_status = dp.vld & dp.write & (dp.addr == REG_STATUS);
  assign wr_div    = dp.vld & dp.write & (dp.addr == REG_DIV);
  assign rd_clr    = dp.vld & ~dp.write & (dp.addr == REG_DATA) & rx_valid;

  assign tx_idle = (tx_count == '0) && (tx_state == TX_IDLE);
  assign status  = {frame_err, overrun, rx_valid, tx_idle, tx_full};

  always_comb begin
    HRDATA = '0;
    if (dp.vld && !dp.write) begin
      case (dp.addr)
        REG_DATA:   HRDATA = rx_valid ? {24'h0, rx_buf} : 32'h0;
        REG_STATUS: HRDATA = {27'h0, status};
        REG_DIV:    HRDATA = {16'h0, div};
        default:    HRDATA = '0;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST)         div <= DIV_RESET;
    else if (wr_div) div <= (HWDATA[15:0] < DIV_MIN) ? DIV_MIN : HWDATA[15:0];
  end

  urv_sync_fifo #(.WIDTH(8), .AW(TXFIFO_AW)) u_txfifo (
    .clk      (CLK),
    .rst      (RST),
    .push     (wr_data),
    .push_dat (HWDATA[7:0]),
    .pop      (tx_pop),
    .pop_dat  (tx_head),
    .full     (tx_full),
    .empty    (tx_empty),
    .count    (tx_count)
  );

  // A new frame starts from IDLE or straight out of the stop bit, so frames run gap-free.
  assign tx_pop = !tx_empty &&
                  ((tx_state == TX_IDLE) || (tx_state == TX_STOP && tx_cnt == '0));

  always_ff @(posedge CLK) begin
    if (RST) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shreg <= '0;
      TXD      <= 1'b1;
    end else if (tx_pop) begin
      tx_state <= TX_START;
      tx_shreg <= tx_head;
      tx_cnt   <= div - 16'd1;
      TXD      <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: TXD <= 1'b1;
        TX_START:
          if (tx_cnt == '0) begin
            tx_state <= TX_DATA;
            tx_idx   <= '0;
            tx_cnt   <= div - 16'd1;
            TXD      <= tx_shreg[0];
          end else tx_cnt <= tx_cnt - 16'd1;
        TX_DATA:
          if (tx_cnt == '0) begin
            tx_cnt <= div - 16'd1;
            if (tx_idx == 3'd7) begin
              tx_state <= TX_STOP;
              TXD      <= 1'b1;
            end else begin
              tx_idx   <= tx_idx + 3'd1;
              tx_shreg <= {1'b0, tx_shreg[7:1]};
              TXD      <= tx_shreg[1];
            end
          end else tx_cnt <= tx_cnt - 16'd1;
        TX_STOP:
          if (tx_cnt == '0) tx_state <= TX_IDLE;
          else              tx_cnt   <= tx_cnt - 16'd1;
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_sync <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[0], RXD};
      rx_prev <= rx_s;
    end
  end
  assign rx_s = rx_sync[1];

  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shreg <= '0;
    end else begin
      case (rx_state)
        RX_IDLE:
          if (rx_prev && !rx_s) begin
            rx_state <= RX_START;
            rx_cnt   <= (div >> 1) - 16'd1;
          end
        RX_START:
          if (rx_cnt == '0) begin
            rx_state <= rx_s ? RX_IDLE : RX_DATA;
            rx_idx   <= '0;
            rx_cnt   <= div - 16'd1;
          end else rx_cnt <= rx_cnt - 16'd1;
        RX_DATA:
          if (rx_cnt == '0) begin
            rx_shreg <= {rx_s, rx_shreg[7:1]};
            rx_cnt   <= div - 16'd1;
            if (rx_idx == 3'd7) rx_state <= RX_STOP;
            else                rx_idx   <= rx_idx + 3'd1;
          end else rx_cnt <= rx_cnt - 16'd1;
        RX_STOP:
          if (rx_cnt == '0) rx_state <= RX_IDLE;
          else              rx_cnt   <= rx_cnt - 16'd1;
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  assign rx_stop_evt = (rx_state == RX_STOP) && (rx_cnt == '0);
  assign rx_stop_ok  = rx_stop_evt & rx_s;

  // A byte landing in the same cycle a DATA read drains the buffer replaces it without overrun.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_buf    <= '0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (rx_stop_ok && (!rx_valid || rd_clr)) begin
        rx_buf   <= rx_shreg;
        rx_valid <= 1'b1;
      end else if (rd_clr) begin
        rx_valid <= 1'b0;
      end
      if (rx_stop_ok && rx_valid && !rd_clr)   overrun <= 1'b1;
      else if (wr_status && HWDATA[ST_OVERRUN]) overrun <= 1'b0;
      if (rx_stop_evt && !rx_s)                  frame_err <= 1'b1;
      else if (wr_status && HWDATA[ST_FRAME_ERR]) frame_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_urv_ahb_uart.sv
// Bench for urv_ahb_uart: register vector table, directed TX/RX sequences, randomized traffic vs a frame-level model.
module tb_urv_ahb_uart;

  logic        CLK = 1'b0;
  logic        RST;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        HRESP;
  logic        TXD;
  logic        RXD;
  logic        IRQ;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int cur_div = 868;
  logic [7:0] tx_got[$];
  int         tx_start[$];

  urv_ahb_uart #(.TXFIFO_AW(3), .DIV_RESET(16'd868)) dut (
    .CLK(CLK), .RST(RST), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE),
    .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(HREADYOUT),
    .HRDATA(HRDATA), .HRESP(HRESP), .TXD(TXD), .RXD(RXD), .IRQ(IRQ)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic bus_idle();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = 32'h0;
  endtask

  task automatic ahb_wr(input logic [3:0] a, input logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {28'h1000000, a};
    wait_cyc(1);
    bus_idle(); HWDATA = d;
    wait_cyc(1);
  endtask

  task automatic ahb_rd(input logic [3:0] a, output logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {28'h1000000, a};
    wait_cyc(1);
    bus_idle();
    d = HRDATA;
    wait_cyc(1);
  endtask

  task automatic rd_chk(input string nm, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] r;
    ahb_rd(a, r);
    chk(nm, r, exp);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop, input int d);
    RXD = 1'b0; wait_cyc(d);
    for (int i = 0; i < 8; i++) begin RXD = b[i]; wait_cyc(d); end
    RXD = stop; wait_cyc(d);
    RXD = 1'b1;
  endtask

  task automatic wait_got(input int n, input int budget);
    int k = 0;
    while (tx_got.size() < n && k < budget) begin wait_cyc(1); k++; end
    chk("tx_frames_seen", tx_got.size(), n);
  endtask

  // Serial line observer: decodes 8N1 frames at mid-bit using the bench's notion of the bit period.
  initial begin : tx_mon
    int d, st;
    logic [7:0] b;
    logic sb, eb;
    forever begin
      wait_cyc(1);
      if (RST === 1'b0 && TXD === 1'b0) begin
        d = cur_div; st = cyc;
        if (d / 2 > 0) wait_cyc(d / 2);
        sb = TXD;
        for (int i = 0; i < 8; i++) begin wait_cyc(d); b[i] = TXD; end
        wait_cyc(d); eb = TXD;
        chk("tx_start_bit", {31'h0, sb}, 32'h0);
        chk("tx_stop_bit", {31'h0, eb}, 32'h1);
        tx_got.push_back(b);
        tx_start.push_back(st);
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation exceeded its time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          wr;
    logic [3:0]  a;
    logic [31:0] d;
    string       nm;
  } vec_t;

  initial begin : main
    vec_t        tbl [0:13];
    logic [31:0] r;
    logic [9:0]  frame;
    logic [7:0]  exp_q[$];
    logic [7:0]  b, m_buf;
    logic        stp, m_valid, m_ov, m_fe;
    int          d, n, nf;

    RST = 1'b1; bus_idle(); HWDATA = '0; HSIZE = 3'b010; HREADY = 1'b1; RXD = 1'b1;
    wait_cyc(3);
    RST = 1'b0;

    chk("rst_txd", {31'h0, TXD}, 32'h1);
    chk("rst_irq", {31'h0, IRQ}, 32'h0);
    chk("rst_hreadyout", {31'h0, HREADYOUT}, 32'h1);
    chk("rst_hresp", {31'h0, HRESP}, 32'h0);
    chk("rst_hrdata", HRDATA, 32'h0);

    tbl = '{
      '{1'b0, 4'h4, 32'h2,        "status_rst"},
      '{1'b0, 4'h8, 32'd868,      "div_rst"},
      '{1'b0, 4'hC, 32'h0,        "rsvd_rd"},
      '{1'b0, 4'h0, 32'h0,        "data_empty"},
      '{1'b1, 4'h8, 32'h1,        "div_wr1"},
      '{1'b0, 4'h8, 32'h2,        "div_clamp"},
      '{1'b1, 4'h8, 32'hABCD1234, "div_wr_wide"},
      '{1'b0, 4'h8, 32'h1234,     "div_low16"},
      '{1'b1, 4'hC, 32'hFFFFFFFF, "rsvd_wr"},
      '{1'b0, 4'hC, 32'h0,        "rsvd_ignored"},
      '{1'b1, 4'h4, 32'hFF,       "status_wr"},
      '{1'b0, 4'h4, 32'h2,        "status_ro_bits"},
      '{1'b1, 4'h8, 32'd16,       "div_wr16"},
      '{1'b0, 4'h8, 32'd16,       "div_16"}
    };
    for (int i = 0; i < 14; i++) begin
      if (tbl[i].wr) ahb_wr(tbl[i].a, tbl[i].d);
      else begin ahb_rd(tbl[i].a, r); chk(tbl[i].nm, r, tbl[i].d); end
    end
    cur_div = 16;

    // Single frame 0x55, checked cycle by cycle from the edge after the push.
    tx_got.delete(); tx_start.delete();
    ahb_wr(4'h0, 32'h55);
    frame = {1'b1, 8'h55, 1'b0};
    for (int k = 0; k < 160; k++) begin
      wait_cyc(1);
      chk($sformatf("tx55_cyc%0d", k), {31'h0, TXD}, {31'h0, frame[k / 16]});
    end
    rd_chk("tx55_status_idle", 4'h4, 32'h2);
    chk("tx55_count", tx_got.size(), 1);
    if (tx_got.size() > 0) chk("tx55_byte", {24'h0, tx_got[0]}, 32'h55);

    // Back-to-back pipelined writes 0x00..0x08, then 0x09 into a full FIFO.
    tx_got.delete(); tx_start.delete();
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h1000_0000;
    wait_cyc(1);
    for (int k = 1; k < 9; k++) begin HWDATA = 32'(k - 1); wait_cyc(1); end
    HWDATA = 32'h8; bus_idle();
    wait_cyc(1);
    rd_chk("b2b_full_after9", 4'h4, 32'h1);
    ahb_wr(4'h0, 32'h9);
    rd_chk("b2b_still_full", 4'h4, 32'h1);
    wait_got(9, 9 * 160 + 100);
    wait_cyc(400);
    chk("b2b_no_extra", tx_got.size(), 9);
    for (int k = 0; k < 9 && k < tx_got.size(); k++) begin
      chk($sformatf("b2b_byte%0d", k), {24'h0, tx_got[k]}, 32'(k));
      if (k > 0) chk($sformatf("b2b_gap%0d", k), tx_start[k] - tx_start[k-1], 160);
    end
    rd_chk("b2b_idle", 4'h4, 32'h2);

    // RX single byte.
    send_rx(8'hA5, 1'b1, 16);
    wait_cyc(4);
    chk("rx_a5_irq", {31'h0, IRQ}, 32'h1);
    rd_chk("rx_a5_status", 4'h4, 32'h6);
    rd_chk("rx_a5_data", 4'h0, 32'hA5);
    rd_chk("rx_a5_status_after", 4'h4, 32'h2);
    chk("rx_a5_irq_clr", {31'h0, IRQ}, 32'h0);

    // Overrun: second byte is discarded.
    send_rx(8'h11, 1'b1, 16);
    send_rx(8'h22, 1'b1, 16);
    wait_cyc(4);
    rd_chk("ovr_data", 4'h0, 32'h11);
    rd_chk("ovr_status", 4'h4, 32'hA);
    chk("ovr_irq", {31'h0, IRQ}, 32'h1);
    ahb_wr(4'h4, 32'h8);
    rd_chk("ovr_cleared", 4'h4, 32'h2);
    chk("ovr_irq_clr", {31'h0, IRQ}, 32'h0);

    // Glitch rejection, then a framing error.
    RXD = 1'b0; wait_cyc(4); RXD = 1'b1;
    wait_cyc(40);
    rd_chk("glitch_status", 4'h4, 32'h2);
    chk("glitch_irq", {31'h0, IRQ}, 32'h0);
    send_rx(8'h3C, 1'b0, 16);
    wait_cyc(4);
    rd_chk("ferr_status", 4'h4, 32'h12);
    chk("ferr_irq", {31'h0, IRQ}, 32'h0);
    ahb_wr(4'h4, 32'h10);
    rd_chk("ferr_cleared", 4'h4, 32'h2);

    // Random TX bursts: serializer takes one byte, FIFO holds 8 more, the rest are dropped.
    for (int it = 0; it < 4; it++) begin
      case ($urandom_range(0, 2))
        0:       d = 5;
        1:       d = 9;
        default: d = 16;
      endcase
      ahb_wr(4'h8, 32'(d));
      cur_div = d;
      tx_got.delete(); tx_start.delete(); exp_q.delete();
      n = $urandom_range(1, 11);
      for (int j = 0; j < n; j++) begin
        b = 8'($urandom);
        ahb_wr(4'h0, {24'h0, b});
        if (j < 9) exp_q.push_back(b);
      end
      wait_got(exp_q.size(), exp_q.size() * 10 * d + 100);
      wait_cyc(20 * d);
      chk($sformatf("rtx%0d_count", it), tx_got.size(), exp_q.size());
      for (int k = 0; k < exp_q.size() && k < tx_got.size(); k++) begin
        chk($sformatf("rtx%0d_byte%0d", it, k), {24'h0, tx_got[k]}, {24'h0, exp_q[k]});
        if (k > 0) chk($sformatf("rtx%0d_gap%0d", it, k), tx_start[k] - tx_start[k-1], 10 * d);
      end
      rd_chk($sformatf("rtx%0d_idle", it), 4'h4, 32'h2);
    end

    // Random RX: one or two frames per round, good or bad stop bit, then drain and clear.
    case ($urandom_range(0, 2))
      0:       d = 8;
      1:       d = 13;
      default: d = 16;
    endcase
    ahb_wr(4'h8, 32'(d));
    cur_div = d;
    m_valid = 1'b0; m_ov = 1'b0; m_fe = 1'b0; m_buf = 8'h0;
    for (int it = 0; it < 6; it++) begin
      nf = $urandom_range(1, 2);
      for (int f = 0; f < nf; f++) begin
        b   = 8'($urandom);
        stp = ($urandom_range(0, 3) != 0);
        send_rx(b, stp, d);
        if (!stp)         m_fe = 1'b1;
        else if (m_valid) m_ov = 1'b1;
        else begin m_buf = b; m_valid = 1'b1; end
      end
      wait_cyc(2 * d);
      chk($sformatf("rrx%0d_irq", it), {31'h0, IRQ}, {31'h0, m_valid | m_ov});
      rd_chk($sformatf("rrx%0d_status", it), 4'h4, {27'h0, m_fe, m_ov, m_valid, 1'b1, 1'b0});
      rd_chk($sformatf("rrx%0d_data", it), 4'h0, m_valid ? {24'h0, m_buf} : 32'h0);
      m_valid = 1'b0;
      rd_chk($sformatf("rrx%0d_status2", it), 4'h4, {27'h0, m_fe, m_ov, 1'b0, 1'b1, 1'b0});
      ahb_wr(4'h4, 32'h18);
      m_ov = 1'b0; m_fe = 1'b0;
    end
    rd_chk("final_status", 4'h4, 32'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
